// File: rtl/conv_row_engine.sv
// conv_row_engine: one row of a KxK multi-channel 2D convolution.
// Loads a KxK kernel per channel and streams IN_W fmap columns through a
// K-column window. One output is produced per accepted column once the window
// is full, and it is accumulated into an OUT_W row buffer across channels.
// The finished row is then drained over a valid/ready port, with optional ReLU.
module conv_row_engine #(
  parameter int DW   = 8,
  parameter int K    = 4,
  parameter int IN_W = 64,
  parameter int ACCW = 25,
  parameter int CIW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_start,
  input  logic [CIW-1:0]         in_cfg_ci,
  input  logic                   in_relu_en,
  input  logic                   in_w_valid,
  output logic                   in_w_ready,
  input  logic [K*DW-1:0]        in_wdata,
  input  logic                   in_f_valid,
  output logic                   in_f_ready,
  input  logic [K*DW-1:0]        in_fdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   out_last,
  output logic                   out_busy,
  output logic                   out_done
);

  localparam int OUT_W = IN_W - K + 1;
  localparam int PW    = 2 * DW;
  localparam int SW    = (ACCW > PW) ? ACCW : PW;
  localparam int XW    = $clog2(IN_W + 1);
  localparam int RW    = $clog2(OUT_W + 1);
  localparam int BW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int KW    = $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN} state_t;

  state_t                  r_state;
  logic [CIW-1:0]          r_ci;
  logic [CIW-1:0]          r_ch;
  logic                    r_relu;
  logic [KW-1:0]           r_kr;
  logic [XW-1:0]           r_x;
  logic [RW-1:0]           r_rd;
  logic signed [DW-1:0]    r_kern [K][K];     // [row][col]
  logic signed [DW-1:0]    r_win  [K-1][K];   // [col][row], oldest column at 0
  logic signed [ACCW-1:0]  r_buf  [OUT_W];

  logic signed [DW-1:0]    w_fcol [K];
  logic signed [DW-1:0]    w_win  [K][K];     // [col][row], incoming column at K-1
  logic signed [SW-1:0]    w_acc;
  logic signed [ACCW-1:0]  w_y;
  logic signed [ACCW-1:0]  w_new;
  logic [BW-1:0]           w_widx;
  logic                    w_buf_we;

  // Sums are kept modulo 2^ACCW; no saturation anywhere in the datapath.
  function automatic logic signed [ACCW-1:0] f_wrap(input logic signed [SW-1:0] v);
    return v[ACCW-1:0];
  endfunction

  function automatic logic signed [ACCW-1:0] f_relu(input logic signed [ACCW-1:0] v,
                                                    input logic en);
    return (en && (v < 0)) ? '0 : v;
  endfunction

  // Split the incoming fmap beat into its K row elements.
  always_comb begin
    for (int r = 0; r < K; r++) w_fcol[r] = in_fdata[r*DW +: DW];
  end

  // Full KxK window: K-1 stored columns plus the column being accepted now.
  always_comb begin
    for (int c = 0; c < K - 1; c++) w_win[c] = r_win[c];
    w_win[K-1] = w_fcol;
  end

  // Full-precision signed products summed in a wide accumulator.
  always_comb begin
    w_acc = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w_acc = w_acc + SW'(r_kern[r][c]) * SW'(w_win[c][r]);
  end

  assign w_y      = f_wrap(w_acc);
  assign w_widx   = BW'(r_x - XW'(K - 1));
  assign w_buf_we = (r_state == S_STREAM) && in_f_valid && (r_x >= XW'(K - 1));
  // Channel 0 overwrites, so stale contents from an earlier or aborted job never leak.
  assign w_new    = (r_ch == '0) ? w_y : w_y + r_buf[w_widx];

  // Row buffer: written on the same edge that accepts the fmap beat.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_widx] <= w_new;
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ci       <= '0;
      r_ch       <= '0;
      r_relu     <= 1'b0;
      r_kr       <= '0;
      r_x        <= '0;
      r_rd       <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) r_kern[r][c] <= '0;
      for (int c = 0; c < K - 1; c++)
        for (int r = 0; r < K; r++) r_win[c][r] <= '0;
      in_w_ready <= 1'b0;
      in_f_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_busy   <= 1'b0;
      out_done   <= 1'b0;
      out_data   <= '0;
    end else begin
      out_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_ci       <= in_cfg_ci;
            r_relu     <= in_relu_en;
            r_ch       <= '0;
            r_kr       <= '0;
            in_w_ready <= 1'b1;
            out_busy   <= 1'b1;
            r_state    <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (in_w_valid) begin
            for (int c = 0; c < K; c++) r_kern[r_kr][c] <= in_wdata[c*DW +: DW];
            r_kr <= r_kr + KW'(1);
            if (r_kr == KW'(K - 1)) begin
              r_kr       <= '0;
              r_x        <= '0;
              in_w_ready <= 1'b0;
              in_f_ready <= 1'b1;
              r_state    <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (in_f_valid) begin
            for (int c = 0; c < K - 2; c++) r_win[c] <= r_win[c+1];
            r_win[K-2] <= w_fcol;
            r_x        <= r_x + XW'(1);
            if (r_x == XW'(IN_W - 1)) begin
              in_f_ready <= 1'b0;
              if (r_ch == r_ci) begin
                r_rd    <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_ch       <= r_ch + CIW'(1);
                in_w_ready <= 1'b1;
                r_state    <= S_LOAD_W;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_busy  <= 1'b0;
              out_done  <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              out_valid <= 1'b1;
              out_data  <= f_relu(r_buf[BW'(r_rd)], r_relu);
              out_last  <= (r_rd == RW'(OUT_W - 1));
              r_rd      <= r_rd + RW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_engine.sv
// Bench for conv_row_engine (K=4, IN_W=8, DW=8, ACCW=25).
// Expected rows come from a direct sum-of-products model over all channels.
module tb_conv_row_engine;

  localparam int DW    = 8;
  localparam int K     = 4;
  localparam int IN_W  = 8;
  localparam int OUT_W = IN_W - K + 1;
  localparam int ACCW  = 25;
  localparam int CIW   = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_start;
  logic [CIW-1:0]         in_cfg_ci;
  logic                   in_relu_en;
  logic                   in_w_valid;
  logic                   in_w_ready;
  logic [K*DW-1:0]        in_wdata;
  logic                   in_f_valid;
  logic                   in_f_ready;
  logic [K*DW-1:0]        in_fdata;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [ACCW-1:0] out_data;
  logic                   out_last;
  logic                   out_busy;
  logic                   out_done;

  conv_row_engine #(.DW(DW), .K(K), .IN_W(IN_W), .ACCW(ACCW), .CIW(CIW)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_cfg_ci(in_cfg_ci),
    .in_relu_en(in_relu_en), .in_w_valid(in_w_valid), .in_w_ready(in_w_ready),
    .in_wdata(in_wdata), .in_f_valid(in_f_valid), .in_f_ready(in_f_ready),
    .in_fdata(in_fdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_busy(out_busy), .out_done(out_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int w_mem [8][K][K];      // [ch][row][col]
  int f_mem [8][K][IN_W];   // [ch][row][x]
  int exp_y [OUT_W];
  bit g_junk = 0;
  bit g_frand = 0;
  bit g_poke = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int ch = 0; ch < 8; ch++)
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++)
          case (kind)
            1:       w_mem[ch][r][c] = (ch == 0) ? 1 : -1;
            3:       w_mem[ch][r][c] = int'($urandom_range(0, 255)) - 128;
            4:       w_mem[ch][r][c] = -128;
            default: w_mem[ch][r][c] = 1;
          endcase
        for (int x = 0; x < IN_W; x++)
          case (kind)
            1:       f_mem[ch][r][x] = (ch == 0) ? 2 : 3;
            2:       f_mem[ch][r][x] = x;
            3:       f_mem[ch][r][x] = int'($urandom_range(0, 255)) - 128;
            4:       f_mem[ch][r][x] = (x % 2 == 0) ? -128 : 127;
            default: f_mem[ch][r][x] = 1;
          endcase
      end
  endtask

  // Reference: y[i] = sum over channels, rows, cols of k*f, wrapped to ACCW bits.
  task automatic compute_exp(input int ci, input bit relu);
    for (int i = 0; i < OUT_W; i++) begin
      longint s = 0;
      logic signed [ACCW-1:0] t;
      for (int ch = 0; ch <= ci; ch++)
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            s += longint'(w_mem[ch][r][c]) * longint'(f_mem[ch][r][i+c]);
      t = s[ACCW-1:0];
      if (relu && t < 0) t = '0;
      exp_y[i] = int'(t);
    end
  endtask

  function automatic logic [K*DW-1:0] pack_w(input int ch, input int r);
    logic [K*DW-1:0] d;
    for (int c = 0; c < K; c++) d[c*DW +: DW] = DW'(w_mem[ch][r][c]);
    return d;
  endfunction

  function automatic logic [K*DW-1:0] pack_f(input int ch, input int x);
    logic [K*DW-1:0] d;
    for (int r = 0; r < K; r++) d[r*DW +: DW] = DW'(f_mem[ch][r][x]);
    return d;
  endfunction

  task automatic start_job(input int ci, input bit relu);
    @(negedge clk);
    in_start = 1'b1; in_cfg_ci = CIW'(ci); in_relu_en = relu;
    @(posedge clk); #1;
    in_start = 1'b0; in_cfg_ci = '0; in_relu_en = 1'b0;
    chk("start_wready", int'(in_w_ready), 1);
    chk("start_busy", int'(out_busy), 1);
  endtask

  task automatic send_w(input int ch, input int r);
    int t = 0;
    bit acc = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      in_wdata = pack_w(ch, r); in_w_valid = 1'b1;
      in_f_valid = g_junk; in_fdata = $urandom;
      acc = in_w_ready;
      @(posedge clk);
      t++;
    end
    if (!acc) begin checks++; errors++; $error("FAIL w_timeout got=%0d exp=%0d", t, 1); end
    #1 in_w_valid = 1'b0; in_f_valid = 1'b0;
  endtask

  task automatic send_f(input int ch, input int x);
    int t = 0;
    int gap;
    bit acc = 0;
    gap = g_frand ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_f_valid = 1'b0; in_w_valid = g_junk; in_wdata = $urandom;
      if (g_poke) begin in_start = 1'b1; in_cfg_ci = 3'd7; in_relu_en = 1'b1; end
    end
    while (!acc && t < 50) begin
      @(negedge clk);
      in_fdata = pack_f(ch, x); in_f_valid = 1'b1;
      in_w_valid = g_junk; in_wdata = $urandom;
      if (g_poke) begin in_start = 1'b1; in_cfg_ci = 3'd7; in_relu_en = 1'b1; end
      acc = in_f_ready;
      @(posedge clk);
      t++;
    end
    if (!acc) begin checks++; errors++; $error("FAIL f_timeout got=%0d exp=%0d", t, 1); end
    #1 in_f_valid = 1'b0; in_w_valid = 1'b0; in_start = 1'b0; in_cfg_ci = '0; in_relu_en = 1'b0;
  endtask

  task automatic load_ch(input int ch, input int nf);
    for (int r = 0; r < K; r++) send_w(ch, r);
    for (int x = 0; x < nf; x++) send_f(ch, x);
  endtask

  // stall: 0 = always ready, 1 = hold ready low 3 cycles at 2nd result, 2 = random.
  task automatic collect(input int stall);
    int idx = 0;
    int t = 0;
    int sc = 0;
    bit rdy;
    while (idx < OUT_W && t < 300) begin
      @(negedge clk);
      t++;
      case (stall)
        0: rdy = 1'b1;
        1: if (out_valid && idx == 1 && sc < 3) begin rdy = 1'b0; sc++; end else rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (out_valid) begin
        chk($sformatf("out_data[%0d]", idx), int'(out_data), exp_y[idx]);
        chk($sformatf("out_last[%0d]", idx), int'(out_last), int'(idx == OUT_W - 1));
        if (rdy) idx++;
      end
    end
    if (idx < OUT_W) begin checks++; errors++; $error("FAIL drain_timeout got=%0d exp=%0d", idx, OUT_W); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("done_pulse", int'(out_done), 1);
    chk("busy_after", int'(out_busy), 0);
    chk("valid_after", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("done_clear", int'(out_done), 0);
  endtask

  task automatic run_job(input int ci, input bit relu, input int stall);
    start_job(ci, relu);
    for (int ch = 0; ch <= ci; ch++) load_ch(ch, IN_W);
    compute_exp(ci, relu);
    collect(stall);
  endtask

  initial begin
    rst = 1'b1; in_start = 1'b0; in_cfg_ci = '0; in_relu_en = 1'b0;
    in_w_valid = 1'b0; in_wdata = '0; in_f_valid = 1'b0; in_fdata = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wready", int'(in_w_ready), 0);
    chk("rst_fready", int'(in_f_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(out_busy), 0);
    chk("rst_data", int'(out_data), 0);
    @(negedge clk); rst = 1'b0;

    // All ones, single channel: five 16s.
    fill(0); run_job(0, 1'b0, 0);

    // Two channels summing to -16, then with ReLU.
    fill(1); run_job(1, 1'b0, 0);
    run_job(1, 1'b1, 0);

    // Ramp: 24,40,56,72,88 with an output stall, then with random fmap gaps.
    fill(2); run_job(0, 1'b0, 1);
    g_frand = 1; run_job(0, 1'b0, 2);

    // Randomized multi-channel jobs with junk on the idle input port.
    g_junk = 1;
    for (int j = 0; j < 4; j++) begin
      fill(3);
      run_job(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2);
    end
    fill(4); run_job(7, 1'b0, 2);
    g_junk = 0; g_frand = 0;

    // Abort during channel 1 streaming.
    fill(3);
    start_job(1, 1'b0);
    load_ch(0, IN_W);
    load_ch(1, 3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_wready", int'(in_w_ready), 0);
    chk("abort_fready", int'(in_f_ready), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_last", int'(out_last), 0);
    chk("abort_busy", int'(out_busy), 0);
    chk("abort_done", int'(out_done), 0);
    chk("abort_data", int'(out_data), 0);
    @(negedge clk); rst = 1'b0;

    // Rerun the all-ones job while poking in_start with a different config.
    fill(0);
    g_poke = 1; run_job(0, 1'b0, 0); g_poke = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
